// File: rtl/lbm_pkg.sv
// Shared widths, FSM encoding and saturation helper for the LBM macroscopic-velocity stage.
package lbm_pkg;

  localparam int LBM_DATA_WIDTH = 64;
  localparam int LBM_FRAC_BITS  = 32;
  localparam int LBM_MAX_WIDTH  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } lbm_state_t;

  // Symmetric clamp: +(2^(w-1)-1) for positive results, -(2^(w-1)-1) for negative ones.
  function automatic logic [LBM_MAX_WIDTH-1:0] sat_limit(input logic neg, input int width);
    logic [LBM_MAX_WIDTH-1:0] pos_lim;
    pos_lim = (LBM_MAX_WIDTH'(1) << (width - 1)) - LBM_MAX_WIDTH'(1);
    return neg ? (~pos_lim + LBM_MAX_WIDTH'(1)) : pos_lim;
  endfunction

endpackage

// File: rtl/lbm_sdiv_iter.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
module lbm_sdiv_iter #(
  parameter int DATA_WIDTH = 64,
  parameter int N          = 96
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [N-1:0]          dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  overflow
);

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [N-1:0]          dq_reg;
  logic [DATA_WIDTH-1:0] rem_reg;
  logic [DATA_WIDTH-1:0] div_reg;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  ge;

  // The divisor is a positive signed value (< 2^(DATA_WIDTH-1)), so the remainder stays
  // below that too and the sign bit of the one-bit-wider difference is a valid compare.
  always_comb begin
    shifted = {rem_reg, dq_reg[N-1]};
    diff    = shifted - {1'b0, div_reg};
    ge      = !diff[DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq_reg  <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (load) begin
      dq_reg  <= dividend;
      rem_reg <= '0;
      div_reg <= divisor;
    end else if (step) begin
      rem_reg <= ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      dq_reg  <= {dq_reg[N-2:0], ge};
    end
  end

  assign quotient = dq_reg[DATA_WIDTH-1:0];
  assign overflow = |dq_reg[N-1:DATA_WIDTH];

endmodule

// File: rtl/lbm_velocity_div.sv
// D2Q9 per-node velocity: ux = jx/rho, uy = jy/rho in signed fixed point, valid/ready in and out.
module lbm_velocity_div
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = LBM_DATA_WIDTH,
  parameter int FRAC_BITS  = LBM_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] rho,
  input  logic [DATA_WIDTH-1:0] jx,
  input  logic [DATA_WIDTH-1:0] jy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ux,
  output logic [DATA_WIDTH-1:0] uy,
  output logic                  div_err
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(N);

  lbm_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [1:0]            neg_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] ux_reg, uy_reg;
  logic                  div_err_reg;

  logic                  accept;
  logic                  rho_bad;
  logic                  div_load;
  logic                  div_step;

  logic [DATA_WIDTH-1:0] j_in    [2];
  logic [DATA_WIDTH-1:0] res     [2];

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign rho_bad   = rho[DATA_WIDTH-1] || (rho == '0);
  assign div_load  = accept && !rho_bad;
  assign div_step  = (state_reg == RUN);

  assign j_in[0] = jx;
  assign j_in[1] = jy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [DATA_WIDTH:0]   j_ext;
      logic [DATA_WIDTH:0]   j_mag;
      logic [N-1:0]          dividend;
      logic [DATA_WIDTH-1:0] q;
      logic                  ovf;
      logic                  sat;

      // One extra bit keeps |most negative| representable.
      assign j_ext    = {j_in[gi][DATA_WIDTH-1], j_in[gi]};
      assign j_mag    = j_in[gi][DATA_WIDTH-1] ? -j_ext : j_ext;
      assign dividend = N'(j_mag) << FRAC_BITS;

      lbm_sdiv_iter #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N)
      ) u_div (
        .clk     (clk),
        .reset   (reset),
        .load    (div_load),
        .dividend(dividend),
        .divisor (rho),
        .step    (div_step),
        .quotient(q),
        .overflow(ovf)
      );

      // Magnitudes at or above 2^(DATA_WIDTH-1) cannot be represented symmetrically.
      assign sat     = ovf || q[DATA_WIDTH-1];
      assign res[gi] = sat ? DATA_WIDTH'(sat_limit(neg_reg[gi], DATA_WIDTH))
                           : (neg_reg[gi] ? -q : q);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = '0;
          state_next = rho_bad ? FIX : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_W'(N - 1)) begin
          state_next = FIX;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      FIX: state_next = DONE;
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      neg_reg     <= '0;
      err_reg     <= 1'b0;
      ux_reg      <= '0;
      uy_reg      <= '0;
      div_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        neg_reg <= {jy[DATA_WIDTH-1], jx[DATA_WIDTH-1]};
        err_reg <= rho_bad;
      end
      if (state_reg == FIX) begin
        ux_reg      <= err_reg ? '0 : res[0];
        uy_reg      <= err_reg ? '0 : res[1];
        div_err_reg <= err_reg;
      end
    end
  end

  assign ux      = ux_reg;
  assign uy      = uy_reg;
  assign div_err = div_err_reg;

endmodule

// File: tb/tb_lbm_velocity_div.sv
// Directed checks of lbm_velocity_div: values, latency, div_err, saturation, backpressure, reset.
module tb_lbm_velocity_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rho, jx, jy;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ux, uy;
  logic        div_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lbm_velocity_div dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rho      (rho),
    .jx       (jx),
    .jy       (jy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ux       (ux),
    .uy       (uy),
    .div_err  (div_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Presents one node in IDLE, then waits (bounded) for out_valid and checks the result.
  task automatic run_node(input string tag, input logic [63:0] r, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] ex_ux,
                          input logic [63:0] ex_uy, input logic ex_err, input int ex_lat);
    int lat;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    rho      = r;
    jx       = x;
    jy       = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rho      = 64'hDEAD_BEEF_0000_0001;
    jx       = {$urandom, $urandom};
    jy       = {$urandom, $urandom};
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(ex_lat));
    chk({tag, ".ux"}, ux, ex_ux);
    chk({tag, ".uy"}, uy, ex_uy);
    chk({tag, ".div_err"}, 64'(div_err), 64'(ex_err));
    $display("node %s: rho=0x%h ux=0x%h uy=0x%h err=%0d latency=%0d", tag, r, ux, uy, div_err, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rho = '0; jx = '0; jy = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.ux", ux, 64'd0);
    chk("rst.uy", uy, 64'd0);
    chk("rst.div_err", 64'(div_err), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;

    run_node("basic", 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_C000_0000,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_C000_0000, 1'b0, 98);
    @(posedge clk); #1;
    chk("basic.idle_in_ready", 64'(in_ready), 64'd1);
    chk("basic.idle_out_valid", 64'(out_valid), 64'd0);

    run_node("third", 64'h0000_0003_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000,
             64'h0000_0000_5555_5555, 64'hFFFF_FFFF_AAAA_AAAB, 1'b0, 98);
    @(posedge clk); #1;

    run_node("rho_zero", 64'h0, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000,
             64'h0, 64'h0, 1'b1, 2);
    @(posedge clk); #1;
    run_node("rho_neg", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000,
             64'h0, 64'h0, 1'b1, 2);
    @(posedge clk); #1;

    run_node("sat_lsb", 64'h1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000,
             64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 98);
    @(posedge clk); #1;

    run_node("extremes", 64'h0000_0002_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
             64'hC000_0000_0000_0000, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0, 98);
    @(posedge clk); #1;
    run_node("most_neg_sat", 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 64'h0,
             64'h8000_0000_0000_0001, 64'h0, 1'b0, 98);
    @(posedge clk); #1;

    // Backpressure: consumer stalls for five cycles after out_valid.
    out_ready = 1'b0;
    run_node("stall", 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 64'hFFFF_FFFF_0000_0000,
             64'h0000_0001_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0, 98);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall.out_valid", 64'(out_valid), 64'd1);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
      chk("stall.ux", ux, 64'h0000_0001_8000_0000);
      chk("stall.uy", uy, 64'hFFFF_FFFF_8000_0000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release.in_ready", 64'(in_ready), 64'd1);
    chk("release.out_valid", 64'(out_valid), 64'd0);
    run_node("back2back", 64'h0000_0004_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFD_0000_0000,
             64'h0000_0000_4000_0000, 64'hFFFF_FFFF_4000_0000, 1'b0, 98);
    @(posedge clk); #1;

    // Reset pulse in the 40th RUN cycle abandons the node.
    rho      = 64'h0000_0001_0000_0000;
    jx       = 64'h0000_0005_0000_0000;
    jy       = 64'h0000_0006_0000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("midrun.out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.ux", ux, 64'd0);
    chk("midrst.uy", uy, 64'd0);
    chk("midrst.div_err", 64'(div_err), 64'd0);
    reset = 1'b0;
    #1;
    chk("postrst.in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("postrst.no_out_valid", 64'(seen), 64'd0);
    run_node("fresh", 64'h0000_0003_0000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000,
             64'h0000_0000_5555_5555, 64'hFFFF_FFFF_AAAA_AAAB, 1'b0, 98);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
